cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
Shares the single multi-cycle main memory between the instruction-cache fill path and the data-cache fill/write-through path. Each grant runs to completion without preemption. A fill issues WORDS_PER_BLOCK pipelined reads to one 16-byte block and forwards each returned word, with its word index, to the owning cache. A data write-through is a single-cycle memory write. Round-robin arbitration prevents either cache from starving the other.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
WORDS_PER_BLOCK, 8, words per cache block (index width 3)
MEM_LAT, 4, cycles from read issue to mem_data_valid (arbiter does not depend on it; informational for bench)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache fill request, held until i_done
i_addr  in  ADDR_W  I-cache miss address
d_req  in  1  D-cache request, held until d_done
d_wr  in  1  with d_req: 1=write-through, 0=block fill
d_addr  in  ADDR_W  D-cache miss/write address
d_wdata  in  DATA_W  write-through data
mem_enable  out  1  memory access strobe
mem_wr  out  1  memory write (valid with mem_enable)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_data_valid  in  1  mem_rdata valid this cycle
fill_data  out  DATA_W  returned word (mem_rdata pass-through)
fill_word  out  3  word index within block of fill_data
i_fill_valid / d_fill_valid  out  1  fill_data is for I / D cache
i_busy / d_busy  out  1  owner's transaction in progress (grant to done, inclusive)
i_done / d_done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE. Reset: state=IDLE, issue_cnt=0, recv_cnt=0, last_served=I. All outputs 0 while in IDLE with no grant.
- Arbitration, in IDLE only:
  - Eligible requester = req high and not masked.
  - Both eligible: grant the one not equal to last_served, so D wins the first tie after reset.
  - On grant: latch address; block base = addr with bits[3:0] cleared; last_served <= grantee; move to state next cycle.
- I_FILL / D_FILL:
  - Issue phase: while issue_cnt < 8, drive mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt++. Exactly 8 consecutive issue cycles.
  - Return: each mem_data_valid drives fill_data=mem_rdata, fill_word=recv_cnt[2:0], and the owner's x_fill_valid (combinational, same cycle); then recv_cnt++.
  - Valids may overlap the issue phase.
  - On the 8th valid: x_done=1 in the same cycle; next state IDLE; counters cleared.
- D_WRITE (one cycle):
  - mem_enable=1, mem_wr=1, mem_addr=latched d_addr (not block-aligned), mem_wdata=latched d_wdata.
  - d_done=1 in the same cycle; next state IDLE.
- Done masking: in the IDLE cycle right after x_done, requester x is masked, because requesters drop req one cycle late. The other requester may be granted in that cycle.
- mem_data_valid in IDLE or D_WRITE: ignored; no fill_valid, no counter change.
- Requests arriving mid-transaction are held pending; no preemption.
- d_wr is sampled only at grant. Changing req, addr or wdata after grant has no effect until done.
- Reset mid-transaction: IDLE next cycle, counters 0, no done pulse. Late valids are ignored.
- Widths: mem_addr arithmetic is ADDR_W bits. base+14 never carries out of the block.

Test Plan:
- I fill alone: i_req=1, i_addr=0x1236 -> mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles. 8 i_fill_valid with fill_word 0..7 and data matching memory. i_done on 8th valid, i_busy high throughout.
- Simultaneous first requests after reset: i_req=d_req=1 (fill), d_addr=0x4000, i_addr=0x0100 -> D served first (0x4000..0x400E). One idle cycle with D masked, then I granted (0x0100..).
- D write-through: d_req=1, d_wr=1, d_addr=0x2346, d_wdata=0xBEEF -> one cycle with mem_enable=1, mem_wr=1, addr=0x2346, wdata=0xBEEF. d_done same cycle; no fill_valid.
- Round-robin under contention: both requests held continuously across 4 transactions -> grant order D,I,D,I; no requester served twice in a row.
- Reset mid-fill: assert rst after the 3rd valid -> IDLE, no i_done. Subsequent stray valids produce no fill_valid. A fresh i_req restarts at word 0.
- Request during fill: d_req raised during I fill issue phase -> ignored until i_done. D granted in the following IDLE cycle; no address overlap on the memory bus.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache fill engines, the shared main memory and
// the arbiter. The arbiter connects through the slave modport; the cache and
// memory side (or a bench standing in for them) uses the master modport.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  // I-cache fill requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_fill_valid;
  logic              i_busy;
  logic              i_done;

  // D-cache fill / write-through requester
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_fill_valid;
  logic              d_busy;
  logic              d_done;

  // Shared return path to whichever cache owns the current fill
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_word;

  // Main memory port
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output i_fill_valid, i_busy, i_done, d_fill_valid, d_busy, d_done,
           fill_data, fill_word, mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  i_fill_valid, i_busy, i_done, d_fill_valid, d_busy, d_done,
           fill_data, fill_word, mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one pipelined main memory between the I-cache fill path and
// the D-cache fill / write-through path. A grant runs to completion; a fill
// issues one read per word of the block back to back and forwards each
// returned word with its index. Round-robin on ties, and a requester is masked
// for the one idle cycle after its done pulse because it drops req late.
module cache_mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input logic           clk,
  input logic           rst,
  cache_mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  // Byte offset bits inside a block: word index plus the byte-in-word bit.
  localparam int OFF_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] RECV_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic              last_d_q, last_d_d;     // 1: D was served last
  logic              mask_i_q, mask_i_d;
  logic              mask_d_q, mask_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic elig_i, elig_d;
  logic grant_i, grant_d;
  logic in_fill, issuing, fill_hit, fill_last;

  // Arbitration and datapath qualifiers derived from current state
  always_comb begin
    elig_i    = bus.i_req & ~mask_i_q;
    elig_d    = bus.d_req & ~mask_d_q;
    // On a tie the requester that was not served last wins.
    grant_d   = (state_q == IDLE) & elig_d & (~elig_i | ~last_d_q);
    grant_i   = (state_q == IDLE) & elig_i & ~grant_d;
    in_fill   = (state_q == I_FILL) | (state_q == D_FILL);
    issuing   = in_fill & (issue_cnt_q < ISSUE_END);
    fill_hit  = in_fill & bus.mem_data_valid;
    fill_last = fill_hit & (recv_cnt_q == RECV_LAST);
  end

  // Next-state: grants, counters, round-robin history and done masking
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    last_d_d    = last_d_q;
    mask_i_d    = 1'b0;
    mask_d_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        if (grant_d) begin
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          last_d_d = 1'b1;
          state_d  = bus.d_wr ? D_WRITE : D_FILL;
        end else if (grant_i) begin
          addr_d   = bus.i_addr;
          last_d_d = 1'b0;
          state_d  = I_FILL;
        end
      end
      I_FILL, D_FILL: begin
        if (issuing) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (fill_hit) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
        end
        if (fill_last) begin
          state_d     = IDLE;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          mask_i_d    = (state_q == I_FILL);
          mask_d_d    = (state_q == D_FILL);
        end
      end
      D_WRITE: begin
        state_d  = IDLE;
        mask_d_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
      end
    endcase
  end

  // Control state register; reset abandons any transaction without a done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      last_d_q    <= 1'b0;
      mask_i_q    <= 1'b0;
      mask_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      last_d_q    <= last_d_d;
      mask_i_q    <= mask_i_d;
      mask_d_q    <= mask_d_d;
    end
  end

  // Latched request address and write data, captured only at grant
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Bus outputs decoded from state; fill return is a same-cycle pass-through
  always_comb begin
    bus.mem_enable   = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.fill_data    = '0;
    bus.fill_word    = '0;
    bus.i_fill_valid = 1'b0;
    bus.d_fill_valid = 1'b0;
    bus.i_busy       = grant_i | (state_q == I_FILL);
    bus.d_busy       = grant_d | (state_q == D_FILL) | (state_q == D_WRITE);
    bus.i_done       = fill_last & (state_q == I_FILL);
    bus.d_done       = (fill_last & (state_q == D_FILL)) | (state_q == D_WRITE);
    if (issuing) begin
      // Block base with the word index spliced in: base + 2*index, never
      // carrying out of the block.
      bus.mem_enable = 1'b1;
      bus.mem_addr   = {addr_q[ADDR_W-1:OFF_W], issue_cnt_q[IDX_W-1:0], 1'b0};
    end else if (state_q == D_WRITE) begin
      bus.mem_enable = 1'b1;
      bus.mem_wr     = 1'b1;
      bus.mem_addr   = addr_q;
      bus.mem_wdata  = wdata_q;
    end
    if (fill_hit) begin
      bus.fill_data    = bus.mem_rdata;
      bus.fill_word    = recv_cnt_q;
      bus.i_fill_valid = (state_q == I_FILL);
      bus.d_fill_valid = (state_q == D_FILL);
    end
  end

endmodule
